// File: rtl/photon_pulse_gate_counter.sv
// Gated rising-edge counter for an asynchronous photon-detector pulse with a saturating total.
// Define PULSE_GLITCH_FILTER_EN to accept an edge only after two consecutive synchronised highs.
module photon_pulse_gate_counter #(
   parameter int unsigned GATE_CYCLES = 50_000_000,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  iMode,
   input  logic        iPulse,
   input  logic        iClr_Accum,
   output logic [31:0] oPulse_Counter,
   output logic        oData_Update,
   output logic [31:0] oPulseCounter_Accumulated,
   output logic        oOverflow
);
   typedef enum logic [1:0] {IDLE, ARM, COUNT, LATCH} state_t;

   localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

   // Returns {saturated, result}; the result never wraps.
   function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? {1'b1, SAT_MAX} : sum;
   endfunction

   function automatic logic [31:0] gate_len(input logic [1:0] mode);
      return 32'(GATE_CYCLES) << mode;
   endfunction

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;
   logic [31:0]            timer_q, timer_d;
   logic [31:0]            gate_q, gate_d;
   logic [31:0]            count_q, count_d;
   logic [31:0]            cnt_out_q, cnt_out_d;
   logic                   upd_q, upd_d;
   logic [31:0]            accum_q, accum_d;
   logic                   ovf_q, ovf_d;
   logic                   level;
   logic                   pulse_edge;
   logic [32:0]            inc_sum;
   logic [32:0]            acc_sum;

   assign sync_d = {sync_q[SYNC_STAGES-2:0], iPulse};

`ifdef PULSE_GLITCH_FILTER_EN
   logic hold_q, hold_d;

   assign hold_d = sync_q[SYNC_STAGES-1];
   assign level  = sync_q[SYNC_STAGES-1] & hold_q;

   always_ff @(posedge clk) begin
      if (!rst_n) hold_q <= 1'b0;
      else        hold_q <= hold_d;
   end
`else
   assign level = sync_q[SYNC_STAGES-1];
`endif

   assign pulse_edge = level & ~prev_q;

   always_comb begin
      state_d   = state_q;
      prev_d    = level;
      timer_d   = timer_q;
      gate_d    = gate_q;
      count_d   = count_q;
      cnt_out_d = cnt_out_q;
      upd_d     = 1'b0;
      accum_d   = accum_q;
      ovf_d     = ovf_q;
      inc_sum   = sat_add(count_q, 32'd1);
      // A clear coinciding with LATCH empties the total before the window is added.
      acc_sum   = sat_add(iClr_Accum ? 32'd0 : accum_q, count_q);

      if (iClr_Accum) begin
         accum_d = '0;
         ovf_d   = 1'b0;
      end

      case (state_q)
         IDLE: begin
            prev_d  = 1'b0;
            timer_d = '0;
            count_d = '0;
            if (en) state_d = ARM;
         end
         ARM: begin
            gate_d  = gate_len(iMode);
            timer_d = '0;
            count_d = '0;
            state_d = COUNT;
         end
         COUNT: begin
            timer_d = timer_q + 32'd1;
            if (pulse_edge) begin
               count_d = inc_sum[31:0];
               if (inc_sum[32]) ovf_d = 1'b1;
            end
            if (timer_q == gate_q - 32'd1) state_d = LATCH;
         end
         LATCH: begin
            cnt_out_d = count_q;
            upd_d     = 1'b1;
            accum_d   = acc_sum[31:0];
            if (acc_sum[32]) ovf_d = 1'b1;
            count_d   = {31'd0, pulse_edge};
            timer_d   = '0;
            gate_d    = gate_len(iMode);
            state_d   = COUNT;
         end
         default: state_d = IDLE;
      endcase

      // Dropping en abandons the partial window; published values stay put.
      if (!en) begin
         state_d = IDLE;
         prev_d  = 1'b0;
         timer_d = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sync_q    <= '0;
         prev_q    <= 1'b0;
         timer_q   <= '0;
         gate_q    <= '0;
         count_q   <= '0;
         cnt_out_q <= '0;
         upd_q     <= 1'b0;
         accum_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sync_q    <= sync_d;
         prev_q    <= prev_d;
         timer_q   <= timer_d;
         gate_q    <= gate_d;
         count_q   <= count_d;
         cnt_out_q <= cnt_out_d;
         upd_q     <= upd_d;
         accum_q   <= accum_d;
         ovf_q     <= ovf_d;
      end
   end

   assign oPulse_Counter            = cnt_out_q;
   assign oData_Update              = upd_q;
   assign oPulseCounter_Accumulated = accum_q;
   assign oOverflow                 = ovf_q;
endmodule

// File: tb/tb_photon_pulse_gate_counter.sv
// Self-checking bench for photon_pulse_gate_counter with GATE_CYCLES=100, SYNC_STAGES=2.
module tb_photon_pulse_gate_counter;
   localparam int G0 = 100;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  iMode = 2'd0;
   logic        iPulse = 1'b0;
   logic        iClr_Accum = 1'b0;
   logic [31:0] oPulse_Counter;
   logic        oData_Update;
   logic [31:0] oPulseCounter_Accumulated;
   logic        oOverflow;

   int     vectors = 0;
   int     miscompares = 0;
   int     cyc = 0;
   longint model_acc = 0;
   bit     model_ovf = 1'b0;

   photon_pulse_gate_counter #(.GATE_CYCLES(G0), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .iMode(iMode), .iPulse(iPulse),
      .iClr_Accum(iClr_Accum), .oPulse_Counter(oPulse_Counter), .oData_Update(oData_Update),
      .oPulseCounter_Accumulated(oPulseCounter_Accumulated), .oOverflow(oOverflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: the window total adds to the running sum, clamped at 2^32-1, flagging overflow.
   function automatic void model_add(input int n);
      model_acc = model_acc + n;
      if (model_acc > 64'h0000_0000_FFFF_FFFF) begin
         model_acc = 64'h0000_0000_FFFF_FFFF;
         model_ovf = 1'b1;
      end
   endfunction

   task automatic drive_pulses(input int n, input int hmin, input int hmax, input int lmin, input int lmax);
      int h, l;
      for (int i = 0; i < n; i++) begin
         h = $urandom_range(hmax, hmin);
         l = $urandom_range(lmax, lmin);
         iPulse = 1'b1;
         repeat (h) @(negedge clk);
         iPulse = 1'b0;
         repeat (l) @(negedge clk);
      end
   endtask

   task automatic wait_strobe(input int budget, output bit got, output int at);
      got = 1'b0;
      at  = cyc;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (oData_Update === 1'b1) begin
            got = 1'b1;
            at  = cyc;
         end
      end
   endtask

   task automatic test_reset();
      bit got; int at, t0;
      rst_n = 1'b0; en = 1'b0;
      repeat (3) @(negedge clk);
      vectors++; if (oPulse_Counter !== 32'd0) begin miscompares++; $display("FAIL rst_cnt: got %0h want 0", oPulse_Counter); end
      vectors++; if (oData_Update !== 1'b0) begin miscompares++; $display("FAIL rst_upd: got %0b want 0", oData_Update); end
      vectors++; if (oPulseCounter_Accumulated !== 32'd0) begin miscompares++; $display("FAIL rst_acc: got %0h want 0", oPulseCounter_Accumulated); end
      vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL rst_ovf: got %0b want 0", oOverflow); end
      rst_n = 1'b1; en = 1'b1;
      wait_strobe(300, got, at);
      vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rst_first_strobe: got %0b want 1", got); end
      t0 = at;
      drive_pulses(5, 2, 3, 2, 3);
      model_add(5);
      wait_strobe(300, got, at);
      vectors++; if (at - t0 !== G0 + 1) begin miscompares++; $display("FAIL rst_interval: got %0d want %0d", at - t0, G0 + 1); end
      vectors++; if (oPulse_Counter !== 32'd5) begin miscompares++; $display("FAIL rst_win_cnt: got %0d want 5", oPulse_Counter); end
      // Five more pulses pending in a window that reset will abandon.
      drive_pulses(5, 2, 3, 2, 3);
      rst_n = 1'b0; en = 1'b0;
      @(negedge clk);
      vectors++; if (oPulse_Counter !== 32'd0) begin miscompares++; $display("FAIL midrst_cnt: got %0h want 0", oPulse_Counter); end
      vectors++; if (oData_Update !== 1'b0) begin miscompares++; $display("FAIL midrst_upd: got %0b want 0", oData_Update); end
      vectors++; if (oPulseCounter_Accumulated !== 32'd0) begin miscompares++; $display("FAIL midrst_acc: got %0h want 0", oPulseCounter_Accumulated); end
      vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL midrst_ovf: got %0b want 0", oOverflow); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_acc = 0; model_ovf = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      bit got; int at, t0;
      int counts [2] = '{7, 3};
      en = 1'b1; iMode = 2'd0;
      wait_strobe(300, got, at);
      vectors++; if (oPulse_Counter !== 32'd0) begin miscompares++; $display("FAIL basic_empty: got %0d want 0", oPulse_Counter); end
      for (int w = 0; w < 2; w++) begin
         t0 = at;
         drive_pulses(counts[w], 3, 3, 3, 3);
         model_add(counts[w]);
         wait_strobe(300, got, at);
         vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL basic_strobe%0d: got %0b want 1", w, got); end
         vectors++; if (at - t0 !== G0 + 1) begin miscompares++; $display("FAIL basic_interval%0d: got %0d want %0d", w, at - t0, G0 + 1); end
         vectors++; if (oPulse_Counter !== 32'(counts[w])) begin miscompares++; $display("FAIL basic_cnt%0d: got %0d want %0d", w, oPulse_Counter, counts[w]); end
         vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL basic_acc%0d: got %0d want %0d", w, oPulseCounter_Accumulated, model_acc); end
      end
      @(negedge clk);
      vectors++; if (oData_Update !== 1'b0) begin miscompares++; $display("FAIL basic_strobe_width: got %0b want 0", oData_Update); end
   endtask

   task automatic test_mode_change();
      bit got; int at, t0;
      wait_strobe(300, got, at);
      model_add(0);
      t0 = at;
      drive_pulses(2, 2, 3, 2, 3);
      iMode = 2'd2;
      drive_pulses(2, 2, 3, 2, 3);
      model_add(4);
      wait_strobe(300, got, at);
      vectors++; if (at - t0 !== G0 + 1) begin miscompares++; $display("FAIL mode_cur_interval: got %0d want %0d", at - t0, G0 + 1); end
      vectors++; if (oPulse_Counter !== 32'd4) begin miscompares++; $display("FAIL mode_cur_cnt: got %0d want 4", oPulse_Counter); end
      t0 = at;
      drive_pulses(3, 2, 3, 2, 3);
      iMode = 2'd0;
      model_add(3);
      wait_strobe(700, got, at);
      vectors++; if (at - t0 !== 4 * G0 + 1) begin miscompares++; $display("FAIL mode_x4_interval: got %0d want %0d", at - t0, 4 * G0 + 1); end
      vectors++; if (oPulse_Counter !== 32'd3) begin miscompares++; $display("FAIL mode_x4_cnt: got %0d want 3", oPulse_Counter); end
      t0 = at;
      model_add(0);
      wait_strobe(700, got, at);
      vectors++; if (at - t0 !== G0 + 1) begin miscompares++; $display("FAIL mode_back_interval: got %0d want %0d", at - t0, G0 + 1); end
      vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL mode_acc: got %0d want %0d", oPulseCounter_Accumulated, model_acc); end
   endtask

   task automatic test_saturation();
      bit got; int at;
      force dut.accum_q = 32'hFFFF_FFF0;
      @(negedge clk);
      release dut.accum_q;
      model_acc = 64'h0000_0000_FFFF_FFF0;
      drive_pulses(20, 2, 2, 2, 2);
      model_add(20);
      wait_strobe(300, got, at);
      vectors++; if (oPulse_Counter !== 32'd20) begin miscompares++; $display("FAIL sat_cnt: got %0d want 20", oPulse_Counter); end
      vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL sat_acc: got %0h want %0h", oPulseCounter_Accumulated, model_acc); end
      vectors++; if (oOverflow !== model_ovf) begin miscompares++; $display("FAIL sat_ovf: got %0b want %0b", oOverflow, model_ovf); end
      iClr_Accum = 1'b1;
      @(negedge clk);
      iClr_Accum = 1'b0;
      model_acc = 0; model_ovf = 1'b0;
      vectors++; if (oPulseCounter_Accumulated !== 32'd0) begin miscompares++; $display("FAIL clr_acc: got %0h want 0", oPulseCounter_Accumulated); end
      vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL clr_ovf: got %0b want 0", oOverflow); end
   endtask

   task automatic test_clr_latch();
      bit got; int at, t0;
      wait_strobe(300, got, at);
      model_add(0);
      drive_pulses(6, 2, 3, 2, 3);
      model_add(6);
      wait_strobe(300, got, at);
      vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL clrl_prior_acc: got %0d want %0d", oPulseCounter_Accumulated, model_acc); end
      t0 = at;
      drive_pulses(4, 2, 3, 2, 3);
      while (cyc < t0 + G0) @(negedge clk);
      iClr_Accum = 1'b1;
      @(negedge clk);
      iClr_Accum = 1'b0;
      model_acc = 0; model_ovf = 1'b0;
      model_add(4);
      vectors++; if (oData_Update !== 1'b1) begin miscompares++; $display("FAIL clrl_strobe: got %0b want 1", oData_Update); end
      vectors++; if (oPulse_Counter !== 32'd4) begin miscompares++; $display("FAIL clrl_cnt: got %0d want 4", oPulse_Counter); end
      vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL clrl_acc: got %0d want %0d", oPulseCounter_Accumulated, model_acc); end
      vectors++; if (oOverflow !== 1'b0) begin miscompares++; $display("FAIL clrl_ovf: got %0b want 0", oOverflow); end
   endtask

   task automatic test_glitch_and_en();
      bit got, seen; int at, t0, c0, exp_n;
      logic [31:0] held_cnt, held_acc; logic held_ovf;
`ifdef PULSE_GLITCH_FILTER_EN
      exp_n = 0;
`else
      exp_n = 5;
`endif
      t0 = cyc;
      drive_pulses(5, 1, 1, 3, 3);
      model_add(exp_n);
      wait_strobe(300, got, at);
      vectors++; if (at - t0 !== G0 + 1) begin miscompares++; $display("FAIL glitch_interval: got %0d want %0d", at - t0, G0 + 1); end
      vectors++; if (oPulse_Counter !== 32'(exp_n)) begin miscompares++; $display("FAIL glitch_cnt: got %0d want %0d", oPulse_Counter, exp_n); end
      held_cnt = 32'(exp_n); held_acc = model_acc[31:0]; held_ovf = model_ovf;
      drive_pulses(3, 2, 3, 2, 3);
      en = 1'b0;
      seen = 1'b0;
      repeat (150) begin
         @(negedge clk);
         if (oData_Update !== 1'b0) seen = 1'b1;
      end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL endrop_strobe: got %0b want 0", seen); end
      vectors++; if (oPulse_Counter !== held_cnt) begin miscompares++; $display("FAIL endrop_cnt: got %0d want %0d", oPulse_Counter, held_cnt); end
      vectors++; if (oPulseCounter_Accumulated !== held_acc) begin miscompares++; $display("FAIL endrop_acc: got %0d want %0d", oPulseCounter_Accumulated, held_acc); end
      vectors++; if (oOverflow !== held_ovf) begin miscompares++; $display("FAIL endrop_ovf: got %0b want %0b", oOverflow, held_ovf); end
      en = 1'b1;
      c0 = cyc;
      repeat (3) @(negedge clk);
      drive_pulses(3, 2, 3, 2, 3);
      model_add(3);
      wait_strobe(300, got, at);
      vectors++; if (at - c0 !== G0 + 3) begin miscompares++; $display("FAIL enrise_latency: got %0d want %0d", at - c0, G0 + 3); end
      vectors++; if (oPulse_Counter !== 32'd3) begin miscompares++; $display("FAIL enrise_cnt: got %0d want 3", oPulse_Counter); end
      vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL enrise_acc: got %0d want %0d", oPulseCounter_Accumulated, model_acc); end
   endtask

   task automatic test_random();
      bit got; int at, t0, n, cur_g, m;
      cur_g = G0;
      for (int w = 0; w < 6; w++) begin
         t0 = cyc;
         m = $urandom_range(3, 0);
         iMode = 2'(m);
         n = $urandom_range(10, 0);
         drive_pulses(n, 2, 4, 2, 4);
         model_add(n);
         wait_strobe(cur_g + 50, got, at);
         vectors++; if (got !== 1'b1) begin miscompares++; $display("FAIL rand_strobe%0d: got %0b want 1", w, got); end
         vectors++; if (at - t0 !== cur_g + 1) begin miscompares++; $display("FAIL rand_interval%0d: got %0d want %0d", w, at - t0, cur_g + 1); end
         vectors++; if (oPulse_Counter !== 32'(n)) begin miscompares++; $display("FAIL rand_cnt%0d: got %0d want %0d", w, oPulse_Counter, n); end
         vectors++; if (oPulseCounter_Accumulated !== model_acc[31:0]) begin miscompares++; $display("FAIL rand_acc%0d: got %0d want %0d", w, oPulseCounter_Accumulated, model_acc); end
         cur_g = G0 << m;
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_mode_change();
      test_saturation();
      test_clr_latch();
      test_glitch_and_en();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
